// File: rtl/spectrum_bar_render.sv
// spectrum_bar_render: 4-bin spectrum bar renderer with peak hold; ports clk, reset_n, valid, mag0..mag3 in, frame_start, pix_valid, pix_x, pix_y in, rgb out (registered)
module spectrum_bar_render #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BAR_W        = 160,
  parameter int GAP          = 8,
  parameter int SHIFT        = 5,
  parameter int DECAY        = 1,
  parameter int STALE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid,
  input  logic signed [31:0] mag0,
  input  logic signed [31:0] mag1,
  input  logic signed [31:0] mag2,
  input  logic signed [31:0] mag3,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [10:0]        pix_x,
  input  logic [10:0]        pix_y,
  output logic [23:0]        rgb
);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] GP = 11'(GAP);
  localparam logic [10:0] DC = 11'(DECAY);
  localparam logic [10:0] B1 = 11'(BAR_W);
  localparam logic [10:0] B2 = 11'(2 * BAR_W);
  localparam logic [10:0] B3 = 11'(3 * BAR_W);
  localparam logic [10:0] XE = 11'((4 * BAR_W < H_ACTIVE) ? 4 * BAR_W : H_ACTIVE);
  localparam logic [7:0]  ST = 8'(STALE_FRAMES);

  function automatic logic [10:0] to_h(input logic signed [31:0] m);
    logic signed [31:0] s;
    s = m >>> SHIFT;
    return m[31] ? 11'd0 : (s > V_ACTIVE ? VA : s[10:0]);
  endfunction

  function automatic logic [10:0] nxt_pk(input logic [10:0] h, input logic [10:0] p);
    logic [10:0] d;
    d = p > DC ? p - DC : 11'd0;
    return h >= p ? h : (d > h ? d : h);
  endfunction

  logic [10:0] hin  [4];
  logic [10:0] pend [4];
  logic [10:0] disp [4];
  logic [10:0] peak [4];
  logic [7:0]  stale, stale_n;
  logic [1:0]  b;
  logic [10:0] off, dh, pk;
  logic        in_col, bar, mark;
  logic [23:0] bar_c, nxt_rgb;

  assign hin[0] = to_h(mag0);
  assign hin[1] = to_h(mag1);
  assign hin[2] = to_h(mag2);
  assign hin[3] = to_h(mag3);
  assign stale_n = stale == ST ? ST : stale + 8'd1;

  always_comb begin
    b = pix_x < B1 ? 2'd0 : pix_x < B2 ? 2'd1 : pix_x < B3 ? 2'd2 : 2'd3;
    off = pix_x - (b == 2'd0 ? 11'd0 : b == 2'd1 ? B1 : b == 2'd2 ? B2 : B3);
    dh = disp[b];
    pk = peak[b];
    in_col = pix_x < XE && off >= GP;
    bar = in_col && pix_y >= VA - dh;
    mark = in_col && pk != 11'd0 && pk < VA && pix_y == VA - 11'd1 - pk;
    bar_c = b == 2'd0 ? 24'hFF0000 : b == 2'd1 ? 24'h00FF00 : b == 2'd2 ? 24'h0000FF : 24'hFFFF00;
    nxt_rgb = !pix_valid ? 24'h0 : mark ? 24'hFFFFFF : bar ? bar_c : 24'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        pend[i] <= '0;
        disp[i] <= '0;
        peak[i] <= '0;
      end
      stale <= '0;
      rgb   <= '0;
    end else begin
      rgb <= nxt_rgb;
      if (frame_start)
        for (int i = 0; i < 4; i++) begin
          disp[i] <= pend[i];
          peak[i] <= nxt_pk(pend[i], peak[i]);
        end
      if (valid) begin
        stale <= '0;
        for (int i = 0; i < 4; i++) pend[i] <= hin[i];
      end else if (frame_start) begin
        stale <= stale_n;
        if (stale_n == ST)
          for (int i = 0; i < 4; i++) pend[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spectrum_bar_render.sv
// tb_spectrum_bar_render: directed self-checking bench for spectrum_bar_render
module tb_spectrum_bar_render;
  logic               clk = 0;
  logic               reset_n = 0;
  logic               valid = 0;
  logic signed [31:0] mag0 = 0, mag1 = 0, mag2 = 0, mag3 = 0;
  logic               frame_start = 0;
  logic               pix_valid = 0;
  logic [10:0]        pix_x = 0, pix_y = 0;
  logic [23:0]        rgb;
  int total = 0;
  int bad = 0;

  spectrum_bar_render dut (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .mag0(mag0), .mag1(mag1), .mag2(mag2), .mag3(mag3),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] e);
    total++;
    assert (rgb === e) else begin
      bad++;
      $error("FAIL %s rgb=%h expected=%h", tag, rgb, e);
    end
  endtask

  task automatic px(input string tag, input logic [10:0] x, input logic [10:0] y, input logic [23:0] e);
    pix_valid = 1;
    pix_x = x;
    pix_y = y;
    tick();
    chk(tag, e);
  endtask

  task automatic cap(input int m0, input int m1, input int m2, input int m3);
    valid = 1;
    mag0 = m0;
    mag1 = m1;
    mag2 = m2;
    mag3 = m3;
    tick();
    valid = 0;
  endtask

  task automatic fs();
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_rgb", 24'h0);
    reset_n = 1;
    px("post_reset_blank", 11'd10, 11'd479, 24'h0);

    cap(3200, 20000, -50, 0);
    px("no_tear_before_fs", 11'd10, 11'd400, 24'h0);
    fs();
    px("bar0_top", 11'd10, 11'd380, 24'hFF0000);
    px("bar0_marker", 11'd10, 11'd379, 24'hFFFFFF);
    px("bar0_above", 11'd10, 11'd378, 24'h0);
    px("bar0_gap", 11'd3, 11'd400, 24'h0);
    px("gap_edge_7", 11'd7, 11'd479, 24'h0);
    px("gap_edge_8", 11'd8, 11'd479, 24'hFF0000);
    px("bar1_full_top", 11'd170, 11'd0, 24'h00FF00);
    px("bar1_full_bot", 11'd168, 11'd479, 24'h00FF00);
    px("bar1_gap", 11'd167, 11'd0, 24'h0);
    px("bar2_neg", 11'd330, 11'd479, 24'h0);
    px("bar3_zero", 11'd639, 11'd479, 24'h0);
    pix_valid = 0;
    pix_x = 11'd10;
    pix_y = 11'd400;
    tick();
    chk("pix_invalid", 24'h0);

    cap(0, 0, 0, 0);
    fs();
    px("decay1_marker", 11'd10, 11'd380, 24'hFFFFFF);
    px("decay1_no_bar", 11'd10, 11'd400, 24'h0);
    px("decay1_old_row", 11'd10, 11'd379, 24'h0);
    px("bin1_peak_row0", 11'd170, 11'd0, 24'hFFFFFF);
    fs();
    px("decay2_marker", 11'd10, 11'd381, 24'hFFFFFF);
    fs();
    px("decay3_marker", 11'd10, 11'd382, 24'hFFFFFF);

    valid = 1;
    frame_start = 1;
    mag0 = 0;
    mag1 = 0;
    mag2 = 0;
    mag3 = 640;
    tick();
    valid = 0;
    frame_start = 0;
    px("coinc_unchanged", 11'd490, 11'd479, 24'h0);
    fs();
    px("bar3_bottom", 11'd490, 11'd479, 24'hFFFF00);
    px("bar3_top", 11'd490, 11'd460, 24'hFFFF00);
    px("bar3_marker", 11'd490, 11'd459, 24'hFFFFFF);
    px("bar3_above", 11'd490, 11'd458, 24'h0);

    cap(3200, 0, 0, 0);
    for (int i = 0; i < 60; i++) fs();
    px("stale_f60_bar", 11'd10, 11'd380, 24'hFF0000);
    fs();
    px("stale_f61_marker", 11'd10, 11'd380, 24'hFFFFFF);
    px("stale_f61_no_bar", 11'd10, 11'd400, 24'h0);
    fs();
    px("stale_f62_marker", 11'd10, 11'd381, 24'hFFFFFF);

    cap(3200, 0, 0, 0);
    fs();
    px("pre_reset_bar", 11'd10, 11'd400, 24'hFF0000);
    reset_n = 0;
    #1;
    chk("async_reset", 24'h0);
    tick();
    chk("reset_hold", 24'h0);
    #2;
    reset_n = 1;
    px("after_reset", 11'd10, 11'd400, 24'h0);
    cap(3200, 0, 0, 0);
    fs();
    px("latency_red", 11'd10, 11'd400, 24'hFF0000);
    pix_valid = 0;
    #1;
    chk("latency_hold", 24'hFF0000);
    tick();
    chk("latency_blank", 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spectrum_bar_render.md
SPECTRUM_BAR_RENDER -- requirements
Module: spectrum_bar_render

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be reset_n, asynchronous and active-low.
REQ-002 Parameters (name, default, meaning):
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BAR_W, 160, pixel width of each of the 4 bin columns.
- GAP, 8, black pixels at the left of each column.
- SHIFT, 5, right-shift from magnitude to bar height.
- DECAY, 1, peak-marker fall per frame, in lines.
- STALE_FRAMES, 60, frames without valid before bars clear.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, async active-low reset.
- valid, in, 1, magnitude set present; stable for at least one full clk cycle.
- mag0..mag3, in, 32 signed each, bin magnitudes.
- frame_start, in, 1, one-cycle pulse before the first active pixel of a frame.
- pix_valid, in, 1, current pixel is in the active region.
- pix_x, in, 11, active column, 0..H_ACTIVE-1.
- pix_y, in, 11, active line, 0..V_ACTIVE-1.
- rgb, out, 24, pixel colour {R,G,B}, registered.

Function
REQ-004 Height conversion SHALL be applied per bin:
- magN < 0 gives 0.
- Otherwise h = magN >>> SHIFT, clamped to V_ACTIVE.
- h is 11 bits unsigned.
REQ-005 Capture: on a rising clk edge with valid=1, all four converted heights SHALL load into the pending register set together.
REQ-006 On a frame_start cycle, the pending set SHALL copy into the display set. The display set SHALL NOT change at any other time, so there is no tearing within a frame.
REQ-007 If valid and frame_start coincide, the display set SHALL take the pending value from before that edge, and the new capture SHALL go to pending only.
REQ-008 Peak hold per bin SHALL update on frame_start, using the height being loaded into display:
- If that height ≥ peak, peak = height.
- Otherwise, peak = max(peak − DECAY, height), saturating at 0.
REQ-009 Stale counter:
- 8-bit, counts frame_start pulses since the last valid.
- Any valid cycle clears it to 0.
- When it reaches STALE_FRAMES on a frame_start, pending SHALL clear to 0 and the counter SHALL hold at STALE_FRAMES.
REQ-010 Column index: bin = 0 for pix_x in 0..BAR_W-1, 1 for BAR_W..2·BAR_W-1, and so on through 3. Columns at pix_x ≥ 4·BAR_W SHALL be background.
REQ-011 The bar of bin b SHALL cover both conditions:
- column offset ≥ GAP;
- pix_y ≥ V_ACTIVE − display_h[b].
REQ-012 The peak marker of bin b SHALL cover both conditions:
- column offset ≥ GAP;
- pix_y = V_ACTIVE − 1 − peak[b], drawn only when peak[b] > 0 and peak[b] < V_ACTIVE.
REQ-013 Colour priority SHALL be: pix_valid=0 gives 000000; otherwise marker FFFFFF, then bar, then background 000000.
REQ-014 Bar colours SHALL be: bin0 FF0000, bin1 00FF00, bin2 0000FF, bin3 FFFF00.
REQ-015 rgb SHALL be registered with a latency of exactly 1 clk from pix_* to rgb.
REQ-016 Arithmetic SHALL be integer only; no divider. Column decode SHALL use comparisons against multiples of BAR_W.

Reset
REQ-017 While reset_n=0, the following SHALL be 0: rgb, pending set, display set, peaks, and the stale counter.
REQ-018 Reset mid-frame SHALL take effect immediately. After release, rgb SHALL be 000000 until capture and frame_start occur.

Verification
REQ-019 Bar height: valid with mag0=3200 (h=100), then frame_start → (x=10,y=380) red; (10,379) white marker; (10,378) black; (3,400) black (gap).
REQ-020 Clamp and sign: mag1=20000 gives h=480, the whole column is green, and there is no marker. mag2=−50 gives h=0 and column 2 is black.
REQ-021 Peak decay: mag0=3200 for one frame, then mag0=0 → marker at rows 379, 380, 381 on successive frames; bar absent.
REQ-022 Coincidence: valid (mag3=640) on the same cycle as frame_start → bar3 is unchanged that frame. The next frame_start shows h=20 (rows 460..479, yellow).
REQ-023 Stale: with no valid for 60 frame_starts after mag0=3200 → at frame 61 bar0 is gone and the marker is decaying.
REQ-024 Reset mid-frame and pix_valid=0 → rgb=000000 on the cycle after; output latency is 1 cycle throughout.
